pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Program-counter stage that consumes the ALU result and produces the next fetch address.
//  Branch instructions drive the ALU in branch mode, so ALU out_val[0] is the selected flag (0/1).
//  This block applies the taken decision, looks up the target in a writable table and advances the PC.
//  It also sequences program start/halt for the testbench and top level.
// PARAMETERS
//  PC_WIDTH    10  fetch address width; all PC arithmetic is modulo 2**PC_WIDTH
//  LUT_ADDR_W  4   target-table index width; table holds 2**LUT_ADDR_W entries of PC_WIDTH bits
// PORTS
//  clk         in   1           rising-edge clock
//  reset       in   1           asynchronous, active-high reset
//  start       in   1           begin execution at PC 0 (sampled in IDLE or HALTED)
//  stall       in   1           hold PC this cycle (current instruction not complete)
//  halt_req    in   1           current instruction is HALT
//  branch      in   1           current instruction is a conditional branch
//  jump        in   1           current instruction is an unconditional jump
//  alu_out     in   8           ALU result; bit 0 = taken flag when branch=1
//  rel         in   1           1: table entry is signed offset from PC; 0: absolute target
//  target_sel  in   LUT_ADDR_W  table index for branch/jump target
//  lut_we      in   1           table write enable
//  lut_waddr   in   LUT_ADDR_W  table write index
//  lut_wdata   in   PC_WIDTH    table write data
//  pc_out      out  PC_WIDTH    current fetch address (registered)
//  running     out  1           1 while in RUN
//  done        out  1           1 while in HALTED
// BEHAVIOUR
//  Reset (async, any time, including mid-run): state=IDLE, pc_out=0, running=0, done=0, all table entries=0.
//  States:
//   IDLE: pc_out holds 0. start=1 -> RUN, pc_out=0.
//   RUN: running=1.
//    - stall=1 has top priority: pc_out holds, and halt_req/branch/jump are ignored.
//    - else halt_req=1 -> HALTED, pc_out holds the HALT address.
//    - else if jump, or (branch and alu_out[0]), redirect (see Target).
//    - else pc_out <= pc_out+1.
//    - jump and branch both high: treated as jump.
//    - alu_out[7:1] is ignored.
//   HALTED: done=1, pc_out holds. start=1 -> RUN, pc_out=0, done=0 the next cycle.
//  Target:
//   rel=1: pc_out <= pc_out + table[target_sel], entry read as two's-complement PC_WIDTH.
//   rel=0: pc_out <= table[target_sel].
//   Sum wraps modulo 2**PC_WIDTH, with no overflow flag.
//  Latency: every PC update is visible on pc_out one clock after the deciding inputs are sampled.
//  Table write:
//   Takes effect at the clock edge and is allowed in every state.
//   A same-cycle write and redirect to the same index uses the OLD entry.
//   The new value is visible from the next cycle.
//  start while in RUN: ignored.
//  Outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
// TESTING
//  1. Reset, start=1 one cycle, 5 plain cycles -> pc_out 0,1,2,3,4,5; running=1; done=0.
//  2. Write table[3]=0x3FE (-2). At pc=5: branch=1, alu_out=8'h01, rel=1, target_sel=3 -> pc_out=3.
//     Same with alu_out=8'h00 -> pc_out=6.
//  3. Write table[1]=0x120. At pc=0x3FF plain step -> 0x000 (wrap). Then jump=1, rel=0, target_sel=1 -> 0x120.
//  4. stall=1 together with halt_req=1 and jump=1 for 3 cycles -> pc_out unchanged, still RUN.
//     Then stall=0, halt_req=1 -> done=1, running=0, pc_out held; start -> pc_out=0, done=0.
//  5. Assert reset asynchronously mid-cycle while in RUN at pc=0x055 -> pc_out=0, running=0, done=0, table reads 0.
//  6. Same-cycle lut_we to index 2 (0x010) and jump rel=0 target_sel=2 with old entry 0x200 -> pc_out=0x200.
//     Next jump to index 2 -> pc_out=0x010.

Source files
------------

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program-counter stage with start/halt sequencing and writable target table
//
// Purpose:
//   Advances the fetch address each non-stalled cycle while running. Redirects
//   to a target taken from a small writable table on jumps and on branches whose
//   ALU flag (alu_out[0]) is set. Sequences IDLE -> RUN -> HALTED, with restart
//   from HALTED on start.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset (state, PC and table cleared)
//   start       begin execution at PC 0 (honoured in IDLE and HALTED only)
//   stall       hold PC; masks halt_req/branch/jump this cycle
//   halt_req    current instruction is HALT
//   branch      current instruction is a conditional branch
//   jump        current instruction is an unconditional jump
//   alu_out     ALU result; only bit 0 (taken flag) is used
//   rel         1: table entry is a signed offset from PC; 0: absolute target
//   target_sel  table index used for the redirect target
//   lut_we      table write enable (any state)
//   lut_waddr   table write index
//   lut_wdata   table write data
//   pc_out      registered fetch address
//   running     1 while in RUN (registered)
//   done        1 while in HALTED (registered)

module pc_unit #(
  parameter int PC_WIDTH   = 10,
  parameter int LUT_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  halt_req,
  input  logic                  branch,
  input  logic                  jump,
  input  logic [7:0]            alu_out,
  input  logic                  rel,
  input  logic [LUT_ADDR_W-1:0] target_sel,
  input  logic                  lut_we,
  input  logic [LUT_ADDR_W-1:0] lut_waddr,
  input  logic [PC_WIDTH-1:0]   lut_wdata,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic                  running,
  output logic                  done
);

  localparam int LUT_DEPTH = 1 << LUT_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] target_lut [LUT_DEPTH];
  logic [PC_WIDTH-1:0] lut_entry;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                take_redirect;

  // Only the taken flag of the ALU result matters here.
  logic unused_alu_bits;
  assign unused_alu_bits = ^alu_out[7:1];

  // Table read uses the pre-edge contents, so a same-cycle write to the
  // selected index does not affect this cycle's redirect.
  always_comb begin
    lut_entry     = target_lut[target_sel];
    // Two's-complement add modulo 2**PC_WIDTH: plain truncated addition.
    redirect_pc   = rel ? (pc_out + lut_entry) : lut_entry;
    take_redirect = jump | (branch & alu_out[0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      pc_out  <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < LUT_DEPTH; i++) begin
        target_lut[i] <= '0;
      end
    end else begin
      if (lut_we) begin
        target_lut[lut_waddr] <= lut_wdata;
      end

      case (state)
        ST_IDLE: begin
          pc_out <= '0;
          if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
            done    <= 1'b0;
          end
        end

        ST_RUN: begin
          if (!stall) begin
            if (halt_req) begin
              state   <= ST_HALTED;
              running <= 1'b0;
              done    <= 1'b1;
            end else if (take_redirect) begin
              pc_out <= redirect_pc;
            end else begin
              pc_out <= pc_out + 1'b1;
            end
          end
        end

        ST_HALTED: begin
          if (start) begin
            state   <= ST_RUN;
            pc_out  <= '0;
            running <= 1'b1;
            done    <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          pc_out  <= '0;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit against a behavioural model

module tb_pc_unit;

  localparam int PW = 10;
  localparam int AW = 4;
  localparam int PC_MOD = 1 << PW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, stall, halt_req, branch, jump, rel, lut_we;
  logic [7:0]    alu_out;
  logic [AW-1:0] target_sel, lut_waddr;
  logic [PW-1:0] lut_wdata;
  logic [PW-1:0] pc_out;
  logic          running, done;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: 0 = idle, 1 = run, 2 = halted; PC kept as integer in [0, PC_MOD).
  int m_state;
  int m_pc;
  int m_tab [1 << AW];

  pc_unit #(.PC_WIDTH(PW), .LUT_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .branch(branch), .jump(jump), .alu_out(alu_out), .rel(rel),
    .target_sel(target_sel), .lut_we(lut_we), .lut_waddr(lut_waddr),
    .lut_wdata(lut_wdata), .pc_out(pc_out), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    start = 0; stall = 0; halt_req = 0; branch = 0; jump = 0; rel = 0;
    lut_we = 0; alu_out = 8'h00; target_sel = '0; lut_waddr = '0; lut_wdata = '0;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 0;
    for (int i = 0; i < (1 << AW); i++) m_tab[i] = 0;
  endtask

  // One clock of architectural behaviour from the current inputs.
  task automatic model_step();
    int old_entry;
    old_entry = m_tab[target_sel];
    if (m_state == 0) begin
      if (start) begin m_state = 1; m_pc = 0; end
    end else if (m_state == 1) begin
      if (!stall) begin
        if (halt_req) m_state = 2;
        else if (jump || (branch && alu_out[0]))
          m_pc = rel ? (m_pc + old_entry) % PC_MOD : old_entry;
        else
          m_pc = (m_pc + 1) % PC_MOD;
      end
    end else begin
      if (start) begin m_state = 1; m_pc = 0; end
    end
    if (lut_we) m_tab[lut_waddr] = int'(lut_wdata);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Write a table entry while holding the PC with stall.
  task automatic write_entry(input int idx, input int val);
    stall = 1; lut_we = 1; lut_waddr = idx[AW-1:0]; lut_wdata = val[PW-1:0];
    cycle();
    stall = 0; lut_we = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    @(posedge clk); #1;
    model_reset();
    reset = 0;
    n_tests++;
    if (pc_out !== '0 || running !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h run=%b done=%b, expected pc=000 run=0 done=0", pc_out, running, done);
    end
    cycle();
    n_tests++;
    if (pc_out !== '0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: pc=%h run=%b, expected pc=000 run=0", pc_out, running);
    end
  endtask

  task automatic test_plain_count();
    start = 1; cycle(); start = 0;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) cycle();
      n_tests++;
      if (pc_out !== PW'(i) || running !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL plain_count[%0d]: pc=%h run=%b done=%b, expected pc=%h run=1 done=0", i, pc_out, running, done, PW'(i));
      end
    end
  endtask

  task automatic test_branch();
    write_entry(3, 'h3FE);
    n_tests++;
    if (pc_out !== 10'h005) begin
      n_fail++;
      $display("FAIL branch_write_hold: pc=%h, expected 005", pc_out);
    end
    branch = 1; alu_out = 8'h01; rel = 1; target_sel = 3;
    cycle();
    n_tests++;
    if (pc_out !== 10'h003) begin
      n_fail++;
      $display("FAIL branch_taken_rel: pc=%h, expected 003", pc_out);
    end
    branch = 0; cycle(); cycle();
    branch = 1; alu_out = 8'h00;
    cycle();
    n_tests++;
    if (pc_out !== 10'h006) begin
      n_fail++;
      $display("FAIL branch_not_taken: pc=%h, expected 006", pc_out);
    end
    alu_out = 8'hFE;
    cycle();
    n_tests++;
    if (pc_out !== 10'h007) begin
      n_fail++;
      $display("FAIL branch_upper_bits_ignored: pc=%h, expected 007", pc_out);
    end
    branch = 0; rel = 0; alu_out = 8'h00;
  endtask

  task automatic test_wrap_jump();
    write_entry(1, 'h120);
    write_entry(4, 'h3FF);
    jump = 1; rel = 0; target_sel = 4;
    cycle();
    jump = 0;
    n_tests++;
    if (pc_out !== 10'h3FF) begin
      n_fail++;
      $display("FAIL jump_abs: pc=%h, expected 3ff", pc_out);
    end
    cycle();
    n_tests++;
    if (pc_out !== 10'h000) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%h, expected 000", pc_out);
    end
    jump = 1; branch = 1; alu_out = 8'h00; target_sel = 1;
    cycle();
    jump = 0; branch = 0;
    n_tests++;
    if (pc_out !== 10'h120) begin
      n_fail++;
      $display("FAIL jump_over_branch: pc=%h, expected 120", pc_out);
    end
    // Relative offset wrapping past the top of the address space.
    write_entry(5, 'h2F0);
    jump = 1; rel = 1; target_sel = 5;
    cycle();
    jump = 0; rel = 0;
    n_tests++;
    if (pc_out !== 10'h010) begin
      n_fail++;
      $display("FAIL rel_wrap: pc=%h, expected 010", pc_out);
    end
  endtask

  task automatic test_stall_halt();
    logic [PW-1:0] held;
    held = pc_out;
    stall = 1; halt_req = 1; jump = 1; target_sel = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if (pc_out !== held || running !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_priority[%0d]: pc=%h run=%b done=%b, expected pc=%h run=1 done=0", i, pc_out, running, done, held);
      end
    end
    stall = 0; jump = 0;
    cycle();
    halt_req = 0;
    n_tests++;
    if (pc_out !== held || running !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_enter: pc=%h run=%b done=%b, expected pc=%h run=0 done=1", pc_out, running, done, held);
    end
    cycle();
    n_tests++;
    if (pc_out !== held || done !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_hold: pc=%h done=%b, expected pc=%h done=1", pc_out, done, held);
    end
    start = 1; cycle(); start = 0;
    n_tests++;
    if (pc_out !== '0 || running !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: pc=%h run=%b done=%b, expected pc=000 run=1 done=0", pc_out, running, done);
    end
    cycle();
    start = 1; cycle(); start = 0;
    n_tests++;
    if (pc_out !== 10'h002) begin
      n_fail++;
      $display("FAIL start_in_run_ignored: pc=%h, expected 002", pc_out);
    end
  endtask

  task automatic test_async_reset();
    write_entry(6, 'h055);
    jump = 1; rel = 0; target_sel = 6;
    cycle();
    jump = 0;
    n_tests++;
    if (pc_out !== 10'h055) begin
      n_fail++;
      $display("FAIL reach_055: pc=%h, expected 055", pc_out);
    end
    #2 reset = 1;
    #1;
    n_tests++;
    if (pc_out !== '0 || running !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h run=%b done=%b, expected pc=000 run=0 done=0", pc_out, running, done);
    end
    @(posedge clk); #3;
    reset = 0;
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    start = 1; cycle(); start = 0;
    jump = 1; rel = 0; target_sel = 6;
    cycle();
    jump = 0;
    n_tests++;
    if (pc_out !== '0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL table_cleared: pc=%h run=%b, expected pc=000 run=1", pc_out, running);
    end
  endtask

  task automatic test_same_cycle_write();
    write_entry(2, 'h200);
    lut_we = 1; lut_waddr = 2; lut_wdata = 10'h010;
    jump = 1; rel = 0; target_sel = 2;
    cycle();
    lut_we = 0;
    n_tests++;
    if (pc_out !== 10'h200) begin
      n_fail++;
      $display("FAIL write_redirect_old: pc=%h, expected 200", pc_out);
    end
    cycle();
    jump = 0;
    n_tests++;
    if (pc_out !== 10'h010) begin
      n_fail++;
      $display("FAIL write_visible_next: pc=%h, expected 010", pc_out);
    end
  endtask

  task automatic test_random();
    int exp_run, exp_done;
    for (int i = 0; i < 400; i++) begin
      start      = ($urandom_range(0, 9) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      halt_req   = ($urandom_range(0, 24) == 0);
      branch     = $urandom_range(0, 1);
      jump       = ($urandom_range(0, 4) == 0);
      alu_out    = 8'($urandom);
      rel        = $urandom_range(0, 1);
      target_sel = AW'($urandom);
      lut_we     = ($urandom_range(0, 2) == 0);
      lut_waddr  = AW'($urandom);
      lut_wdata  = PW'($urandom);
      cycle();
      exp_run  = (m_state == 1);
      exp_done = (m_state == 2);
      n_tests++;
      if (pc_out !== m_pc[PW-1:0] || running !== exp_run[0] || done !== exp_done[0]) begin
        n_fail++;
        $display("FAIL random[%0d]: pc=%h run=%b done=%b, expected pc=%h run=%0d done=%0d", i, pc_out, running, done, m_pc[PW-1:0], exp_run, exp_done);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    model_reset();
    test_reset();
    test_plain_count();
    test_branch();
    test_wrap_jump();
    test_stall_halt();
    test_async_reset();
    test_same_cycle_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
